multiplexador_arbitrado: RTL and testbench
==========================================

Name: multiplexador_arbitrado

Overview:
- Parametrised N-channel, LARGURA-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Two modes: fixed selection by `controle`, or round-robin arbitration among requesting channels.
- Output is held in a single register stage, so the selected word appears one cycle after acceptance.
- Sits between the register-file/ALU sources and shared consumers.
- Successor of the fixed 8:1 16-bit combinational selector.

Parameters:
- LARGURA, 16: data width per channel, ≥1.
- N, 8: channel count, 2..64. Need not be a power of two.
- SEL, $clog2(N): width of `controle` and `canal`. Derived; do not override.

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous reset, active-low.
- entradas, input, N*LARGURA: channel i occupies bits [i*LARGURA +: LARGURA].
- validos, input, N: channel i presents valid data.
- prontos, output, N: channel i's word is accepted this cycle.
- modo, input, 1: 0 = fixed select by `controle`; 1 = round-robin.
- controle, input, SEL: selected channel in fixed mode.
- saida, output, LARGURA: registered output data.
- saida_valida, output, 1: `saida` holds a word.
- saida_pronta, input, 1: consumer accepts `saida` this cycle.
- canal, output, SEL: index of the channel whose word is in `saida`.
- erro_sel, output, 1: sticky flag, set when fixed mode selects `controle` ≥ N.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - saida = 0, saida_valida = 0, canal = 0, erro_sel = 0, round-robin pointer ptr = 0.
  - prontos = 0 while reset_n = 0.
  - A word held at reset is discarded.
- carregar = ~saida_valida | saida_pronta. The output register may load this cycle.
- Grant (combinational, at most one bit set):
  - modo = 0: grant[controle] = validos[controle] when controle < N. No grant when controle ≥ N.
  - modo = 1: grant goes to the first i with validos[i] = 1, searching ptr, ptr+1, … N-1, 0, … ptr-1 (wrap mod N, not mod 2^SEL).
- prontos = grant & {N{carregar}}. Purely combinational; no dependence on a prontos→validos loop.
- Transfer on a rising edge when |(validos & prontos):
  - saida <= selected word; canal <= selected index; saida_valida <= 1.
  - If modo = 1: ptr <= (index+1 == N) ? 0 : index+1.
- If saida_pronta & saida_valida and there is no transfer: saida_valida <= 0. saida and canal hold their last value.
- Simultaneous drain and load: new word replaces old in the same edge. This gives full throughput of one word per cycle.
- Latency: input accepted at edge k, visible on saida after edge k.
- Backpressure: while saida_valida = 1 and saida_pronta = 0, prontos = 0 and all outputs hold.
- ptr does not change in modo = 0.
- Switching modo takes effect in the same cycle's grant. ptr is retained across mode switches.
- erro_sel is set when modo = 0 and controle ≥ N, and is cleared only by reset. It cannot occur when N is a power of two.
- No request (validos = 0): no transfer, ptr holds.

Test Plan:
- Reset: drive reset_n = 0 mid-transfer with saida_valida = 1.
  - Expect saida = 0, saida_valida = 0, canal = 0, prontos = 0 immediately, without a clock edge.
- Fixed mode, N = 8, LARGURA = 16: modo = 0, controle = 5, validos = 8'hFF, entradas[5] = 16'hA5A5, saida_pronta = 1.
  - Expect prontos = 8'h20, and saida = 16'hA5A5, canal = 5 after one edge.
- Round-robin fairness: modo = 1, validos = 8'b1001_0010 held, saida_pronta = 1.
  - Expect grant sequence 1, 4, 7, 1, 4 on consecutive cycles, with canal following one cycle later.
- Backpressure: saida_valida = 1, saida_pronta = 0 for 3 cycles.
  - Expect prontos = 0, saida/canal unchanged, ptr unchanged.
  - Then saida_pronta = 1: expect the next word is loaded in that same edge.
- Non-power-of-two, N = 6: modo = 1, validos = 6'b100001, ptr = 5.
  - Expect grant 5, then wrap to 0, then 5.
  - Then modo = 0, controle = 7: expect prontos = 0, no transfer, erro_sel = 1 after the edge and staying 1.
- Drain without refill: validos = 0, saida_valida = 1, saida_pronta = 1.
  - Expect saida_valida = 0 next cycle, saida value retained.

Source files
------------

// File: rtl/multiplexador_arbitrado.sv
// multiplexador_arbitrado: N-channel registered multiplexer with valid/ready
// handshakes, fixed selection or round-robin arbitration among requesters.
module multiplexador_arbitrado #(
    parameter int LARGURA = 16,
    parameter int N       = 8,
    parameter int SEL     = $clog2(N)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N*LARGURA-1:0] entradas,
    input  logic [N-1:0]         validos,
    output logic [N-1:0]         prontos,
    input  logic                 modo,
    input  logic [SEL-1:0]       controle,
    output logic [LARGURA-1:0]   saida,
    output logic                 saida_valida,
    input  logic                 saida_pronta,
    output logic [SEL-1:0]       canal,
    output logic                 erro_sel
);

    logic [LARGURA-1:0] r_saida;
    logic               r_valida;
    logic [SEL-1:0]     r_canal;
    logic               r_erro;
    logic [SEL-1:0]     r_ptr;

    logic               w_carregar;
    logic               w_fora;
    logic [N-1:0]       w_grant;
    logic [SEL-1:0]     w_idx;
    logic [SEL:0]       w_rr;
    logic               w_transfer;
    logic [SEL-1:0]     w_ptr_prox;
    logic [LARGURA-1:0] w_dado;

    // Scans ptr, ptr+1 .. N-1, 0 .. ptr-1 and returns {found, index} of the first
    // requester; the wrap is modulo N so non-power-of-two counts behave.
    function automatic logic [SEL:0] buscaRoundRobin(input logic [N-1:0] v,
                                                      input logic [SEL-1:0] p);
        logic [SEL:0] res;
        int           idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(p) + k;
            if (idx >= N) idx = idx - N;
            if (v[idx]) res = {1'b1, idx[SEL-1:0]};
        end
        return res;
    endfunction

    assign w_carregar = ~r_valida | saida_pronta;
    assign w_fora     = (int'(controle) >= N);
    assign w_rr       = buscaRoundRobin(validos, r_ptr);

    // Grant selection: one-hot (or empty) grant plus the index it points to.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        if (!modo) begin
            if (!w_fora) begin
                w_grant[controle] = validos[controle];
                w_idx             = controle;
            end
        end else begin
            w_idx = w_rr[SEL-1:0];
            if (w_rr[SEL]) w_grant[w_rr[SEL-1:0]] = 1'b1;
        end
    end

    assign prontos    = w_grant & {N{w_carregar}} & {N{reset_n}};
    assign w_transfer = |(validos & prontos);
    assign w_dado     = entradas[w_idx*LARGURA +: LARGURA];
    assign w_ptr_prox = (int'(w_idx) + 1 == N) ? '0 : w_idx + SEL'(1);

    // Output register: load on transfer (replacing any drained word), otherwise
    // drop the valid flag once the consumer takes the held word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_saida  <= '0;
            r_valida <= 1'b0;
            r_canal  <= '0;
            r_ptr    <= '0;
        end else begin
            if (w_transfer) begin
                r_saida  <= w_dado;
                r_canal  <= w_idx;
                r_valida <= 1'b1;
                if (modo) r_ptr <= w_ptr_prox;
            end else if (saida_pronta && r_valida) begin
                r_valida <= 1'b0;
            end
        end
    end

    // Sticky flag for an out-of-range fixed selection; only reset clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_erro <= 1'b0;
        end else if (!modo && w_fora) begin
            r_erro <= 1'b1;
        end
    end

    assign saida        = r_saida;
    assign saida_valida = r_valida;
    assign canal        = r_canal;
    assign erro_sel     = r_erro;

endmodule

// File: tb/tb_multiplexador_arbitrado.sv
// tb_multiplexador_arbitrado: directed checks of an 8x16 instance and a 6x8
// instance (non-power-of-two wrap and out-of-range fixed selection).
module tb_multiplexador_arbitrado;

    logic         clock;
    logic         reset_n;

    logic [127:0] ent8;
    logic [7:0]   val8;
    logic [7:0]   pr8;
    logic         modo8;
    logic [2:0]   ctl8;
    logic [15:0]  sai8;
    logic         sv8;
    logic         sp8;
    logic [2:0]   can8;
    logic         err8;

    logic [47:0]  ent6;
    logic [5:0]   val6;
    logic [5:0]   pr6;
    logic         modo6;
    logic [2:0]   ctl6;
    logic [7:0]   sai6;
    logic         sv6;
    logic         sp6;
    logic [2:0]   can6;
    logic         err6;

    int nChecks = 0;
    int nFails  = 0;

    multiplexador_arbitrado #(.LARGURA(16), .N(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .entradas(ent8), .validos(val8),
        .prontos(pr8), .modo(modo8), .controle(ctl8), .saida(sai8),
        .saida_valida(sv8), .saida_pronta(sp8), .canal(can8), .erro_sel(err8)
    );

    multiplexador_arbitrado #(.LARGURA(8), .N(6)) dut6 (
        .clock(clock), .reset_n(reset_n), .entradas(ent6), .validos(val6),
        .prontos(pr6), .modo(modo6), .controle(ctl6), .saida(sai6),
        .saida_valida(sv6), .saida_pronta(sp6), .canal(can6), .erro_sel(err6)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compares one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Advances to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Applies new inputs to the 8-channel instance and lets them settle.
    task automatic applyStimulus(input logic m, input logic [2:0] c, input logic [7:0] v, input logic p);
        modo8 = m;
        ctl8  = c;
        val8  = v;
        sp8   = p;
        #1;
    endtask

    initial begin
        int rrSeq[5];
        reset_n = 1'b0;
        ent8 = '0; val8 = '0; modo8 = 1'b0; ctl8 = '0; sp8 = 1'b0;
        ent6 = '0; val6 = '0; modo6 = 1'b0; ctl6 = '0; sp6 = 1'b0;
        #12;
        checkOutput("rst_saida", 32'(sai8), 32'h0);
        checkOutput("rst_valida", 32'(sv8), 32'h0);
        checkOutput("rst_canal", 32'(can8), 32'h0);
        checkOutput("rst_erro", 32'(err8), 32'h0);
        tick();
        reset_n = 1'b1;

        // Fixed mode: controle = 5, all channels valid.
        for (int i = 0; i < 8; i++) ent8[i*16 +: 16] = 16'(i * 16'h1111);
        ent8[5*16 +: 16] = 16'hA5A5;
        applyStimulus(1'b0, 3'd5, 8'hFF, 1'b1);
        checkOutput("fix_prontos", 32'(pr8), 32'h20);
        tick();
        checkOutput("fix_saida", 32'(sai8), 32'hA5A5);
        checkOutput("fix_canal", 32'(can8), 32'd5);
        checkOutput("fix_valida", 32'(sv8), 32'h1);

        // Round-robin over channels 1, 4, 7 starting from ptr = 0.
        for (int i = 0; i < 8; i++) ent8[i*16 +: 16] = 16'(16'h1000 + i);
        rrSeq = '{1, 4, 7, 1, 4};
        applyStimulus(1'b1, 3'd0, 8'b1001_0010, 1'b1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("rr_prontos%0d", k), 32'(pr8), 32'(8'(1) << rrSeq[k]));
            tick();
            checkOutput($sformatf("rr_canal%0d", k), 32'(can8), 32'(rrSeq[k]));
            checkOutput($sformatf("rr_saida%0d", k), 32'(sai8), 32'h1000 + 32'(rrSeq[k]));
        end

        // Backpressure: consumer stalls three cycles, everything holds.
        applyStimulus(1'b1, 3'd0, 8'b1001_0010, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("bp_prontos%0d", k), 32'(pr8), 32'h0);
            tick();
            checkOutput($sformatf("bp_canal%0d", k), 32'(can8), 32'd4);
            checkOutput($sformatf("bp_saida%0d", k), 32'(sai8), 32'h1004);
            checkOutput($sformatf("bp_valida%0d", k), 32'(sv8), 32'h1);
        end
        applyStimulus(1'b1, 3'd0, 8'b1001_0010, 1'b1);
        checkOutput("bp_release_prontos", 32'(pr8), 32'h80);
        tick();
        checkOutput("bp_release_canal", 32'(can8), 32'd7);
        checkOutput("bp_release_saida", 32'(sai8), 32'h1007);

        // Drain without refill.
        applyStimulus(1'b1, 3'd0, 8'h00, 1'b1);
        tick();
        checkOutput("drain_valida", 32'(sv8), 32'h0);
        checkOutput("drain_saida", 32'(sai8), 32'h1007);
        checkOutput("drain_canal", 32'(can8), 32'd7);
        checkOutput("n8_erro", 32'(err8), 32'h0);

        // N = 6: move ptr to 5 via channel 4, then wrap 5 -> 0 -> 5.
        for (int i = 0; i < 6; i++) ent6[i*8 +: 8] = 8'(8'h50 + i);
        modo6 = 1'b1; sp6 = 1'b1; val6 = 6'b010000;
        #1;
        checkOutput("n6_pre_prontos", 32'(pr6), 32'h10);
        tick();
        checkOutput("n6_pre_canal", 32'(can6), 32'd4);
        val6 = 6'b100001;
        #1;
        checkOutput("n6_prontos_a", 32'(pr6), 32'h20);
        tick();
        checkOutput("n6_canal_a", 32'(can6), 32'd5);
        checkOutput("n6_saida_a", 32'(sai6), 32'h55);
        checkOutput("n6_prontos_b", 32'(pr6), 32'h01);
        tick();
        checkOutput("n6_canal_b", 32'(can6), 32'd0);
        checkOutput("n6_saida_b", 32'(sai6), 32'h50);
        checkOutput("n6_prontos_c", 32'(pr6), 32'h20);
        tick();
        checkOutput("n6_canal_c", 32'(can6), 32'd5);

        // N = 6 fixed mode with controle = 7: no grant, sticky error.
        modo6 = 1'b0; ctl6 = 3'd7; val6 = 6'h3F;
        #1;
        checkOutput("n6_oor_prontos", 32'(pr6), 32'h0);
        checkOutput("n6_oor_erro_pre", 32'(err6), 32'h0);
        tick();
        checkOutput("n6_oor_erro", 32'(err6), 32'h1);
        checkOutput("n6_oor_valida", 32'(sv6), 32'h0);
        checkOutput("n6_oor_canal", 32'(can6), 32'd5);
        ctl6 = 3'd2;
        #1;
        checkOutput("n6_fix_prontos", 32'(pr6), 32'h04);
        tick();
        checkOutput("n6_fix_canal", 32'(can6), 32'd2);
        checkOutput("n6_erro_sticky", 32'(err6), 32'h1);

        // Asynchronous reset while a word is held and a requester is pending.
        applyStimulus(1'b1, 3'd0, 8'h02, 1'b1);
        tick();
        checkOutput("pre_rst_valida", 32'(sv8), 32'h1);
        checkOutput("pre_rst_canal", 32'(can8), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_saida", 32'(sai8), 32'h0);
        checkOutput("arst_valida", 32'(sv8), 32'h0);
        checkOutput("arst_canal", 32'(can8), 32'h0);
        checkOutput("arst_prontos", 32'(pr8), 32'h0);
        checkOutput("arst_erro6", 32'(err6), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
